dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Multi-cycle data-memory responder serving the pipeline's MEM-stage load/store requests over a req/ack handshake. It replaces the single-cycle data memory so that realistic memory latency can be modelled. It drives a stall back to the hazard logic, so PC, IF_ID, ID_EX and EX_MEM freeze while an access is outstanding. It holds the word-addressed data storage.

Parameters:
DEPTH, 256, number of 32-bit words stored; must be a power of two, at least 4.
LATENCY, 3, cycles from request acceptance to ack; legal range 1..15.
AW, 8, word-index width; equals log2(DEPTH).

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
rst_i  input  1  synchronous, active-high reset.
req_i  input  1  MEM stage requests an access; held stable by the requester until ack_o.
we_i  input  1  1 = store, 0 = load; sampled at acceptance.
addr_i  input  32  byte address; bits [1:0] ignored.
wdata_i  input  32  store data; sampled at acceptance.
rdata_o  output  32  load data; valid while ack_o=1; held until the next completed load.
ack_o  output  1  one-cycle pulse marking completion.
err_o  output  1  pulses with ack_o when the address is out of range.
stall_o  output  1  combinational; equals req_i AND NOT ack_o.

Behaviour:
- Reset values, applied when rst_i=1 at an edge: state IDLE, ack_o=0, err_o=0, rdata_o=0, counter=0, captured request cleared.
- Reset does not clear storage contents. The bench preloads storage via hierarchical access.
- Reset mid-access: state returns to IDLE and any pending store is discarded, with no partial write.
- FSM states:
  - IDLE: if req_i=1, accept the request. Capture we_i, addr_i[AW+1:2], the range check, and wdata_i. Load counter with LATENCY-1. Next state is BUSY, or DONE if LATENCY=1.
  - BUSY: decrement the counter each cycle. When the counter is 1, the next state is DONE. req_i, we_i, addr_i and wdata_i are ignored; captured values are used.
  - DONE: ack_o=1 for exactly this cycle. Next state is always IDLE.
- Timing: a request accepted at edge N gives ack_o=1 in the cycle following edge N+LATENCY-1, so stall_o is high for exactly LATENCY cycles per access.
- Effects on entering DONE:
  - Store: storage[idx] <= wdata is written on the edge that enters DONE.
  - Load: rdata_o <= storage[idx] is registered on the same edge.
- After DONE the responder always returns to IDLE, so there is one idle cycle between accesses. A req_i still high in IDLE is treated as a new request; the pipeline advances on the ack edge, so req_i then reflects the next instruction.
- Out of range means addr_i[31:AW+2] != 0. The access completes with normal timing and err_o=1 alongside ack_o. A load returns rdata_o=0; a store is dropped.
- Store then load to the same address: the load sees the new data, because the store committed at an earlier edge.
- rdata_o is unchanged by stores and by idle cycles.
- ack_o and err_o are never high outside DONE.
- stall_o is 0 whenever req_i=0, including during reset.

Decomposition:
- Shared package: state enum (IDLE, BUSY, DONE), the DATA_W=32 constant, and the counter width constant CNT_W=4.
- One sub-module, dmem_array: a single-port synchronous word storage (clock, we, idx, wdata, rdata) with no reset.
- The FSM, counter, capture registers and range check stay in dmem_responder.

Test Plan:
- LATENCY=3. Store 0xDEADBEEF to addr 0x10 with req held -> stall_o=1 for 3 cycles; ack_o pulses in the 3rd cycle; err_o=0; the word at index 4 is 0xDEADBEEF.
- Load from addr 0x10 after the store -> ack_o after 3 cycles with rdata_o=0xDEADBEEF; rdata_o still 0xDEADBEEF 5 cycles later with req_i=0.
- Back-to-back: store 0x1 to 0x20, then immediately load 0x20 -> second ack exactly 4 cycles after the first (1 IDLE + 3); rdata_o=0x00000001.
- Change addr_i to 0x30 during BUSY of a load from 0x20 -> data returned from 0x20; 0x30 untouched.
- Assert rst_i in the 2nd cycle of a store of 0x55 to 0x40 -> no ack; word 0x40 keeps its old value; ack_o=0, rdata_o=0 after reset; the next request has full LATENCY.
- Load from addr 0x400 (DEPTH=256) -> ack_o=1, err_o=1, rdata_o=0. A store to 0x400 also gives err_o=1 and modifies no storage. Rerun with LATENCY=1: ack in the cycle after acceptance, stall_o high for 1 cycle.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// The range check lives here so the top and any future users agree on it.
package dmem_responder_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Any set bit above the word-index field means the word is not stored.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int aw);
        logic [31:0] w_mask;
        w_mask = ~((32'd1 << (aw + 2)) - 32'd1);
        return (addr & w_mask) != 32'd0;
    endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Word-addressed data storage: synchronous write, combinational read, no reset.
// Contents survive reset so preloaded data remains valid.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store responder with configurable latency and stall output.
//   state | meaning
//   IDLE  | waiting for req_i; accepts and captures the request
//   BUSY  | counting down the remaining latency on captured values
//   DONE  | ack_o (and err_o if out of range) for exactly one cycle
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              ack_o,
    output logic              err_o,
    output logic              stall_o
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    logic              r_we;
    logic [AW-1:0]     r_idx;
    logic              r_oor;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              w_accept;
    logic              w_req_oor;
    logic              w_enter_done;
    logic              w_cur_we;
    logic              w_cur_oor;
    logic [AW-1:0]     w_cur_idx;
    logic [DATA_W-1:0] w_cur_wdata;
    logic              w_arr_we;
    logic [DATA_W-1:0] w_arr_rdata;
    logic              w_unused;

    assign w_unused  = &{1'b0, addr_i[1:0]};
    assign w_req_oor = addr_out_of_range(addr_i, AW);
    assign w_accept  = (r_state == IDLE) && req_i;

    // With LATENCY=1 DONE is entered on the accept edge, so the live inputs
    // must feed the array before they land in the capture registers.
    assign w_cur_we    = w_accept ? we_i              : r_we;
    assign w_cur_idx   = w_accept ? addr_i[AW+1:2]    : r_idx;
    assign w_cur_oor   = w_accept ? w_req_oor         : r_oor;
    assign w_cur_wdata = w_accept ? wdata_i           : r_wdata;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (req_i) begin
                    w_cnt_nxt   = CNT_W'(LATENCY - 1);
                    w_state_nxt = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_enter_done = (w_state_nxt == DONE);
    assign w_arr_we     = w_enter_done && w_cur_we && !w_cur_oor && !rst_i;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clk   (clk_i),
        .i_we    (w_arr_we),
        .i_idx   (w_cur_idx),
        .i_wdata (w_cur_wdata),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_oor   <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= we_i;
                r_idx   <= addr_i[AW+1:2];
                r_oor   <= w_req_oor;
                r_wdata <= wdata_i;
            end
            if (w_enter_done && !w_cur_we) begin
                r_rdata <= w_cur_oor ? '0 : w_arr_rdata;
            end
        end
    end

    assign ack_o   = (r_state == DONE);
    assign err_o   = ack_o && r_oor;
    assign stall_o = req_i && !ack_o;
    assign rdata_o = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=3 and LATENCY=1 instances, table vectors
// with a scoreboard, plus hand sequences for hold, BUSY isolation and reset.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req3 = 1'b0, we3 = 1'b0;
    logic [31:0] addr3 = '0, wdata3 = '0, rdata3;
    logic        ack3, err3, stall3;
    logic        req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr1 = '0, wdata1 = '0, rdata1;
    logic        ack1, err1, stall1;

    dmem_responder #(.DEPTH(256), .LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req3), .we_i(we3), .addr_i(addr3),
        .wdata_i(wdata3), .rdata_o(rdata3), .ack_o(ack3), .err_o(err3), .stall_o(stall3)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1),
        .wdata_i(wdata1), .rdata_o(rdata1), .ack_o(ack1), .err_o(err1), .stall_o(stall1)
    );

    typedef struct {
        bit          l1;
        bit          b2b;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
    } vec_t;

    typedef struct {
        bit          we;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rd [2];
    vec_t        vecs [13];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [31:0] pre(input int i);
        return 32'hA500_0000 | (32'(i) << 8) | 32'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit l1, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (l1) begin
            req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req3 = req; we3 = we; addr3 = addr; wdata3 = wdata;
        end
    endtask

    task automatic run_vec(input vec_t v, input bit hold, input int k);
        exp_t e;
        int   gap, stalls, lat, m;
        bit   a;
        m   = v.l1 ? 1 : 0;
        lat = v.l1 ? 1 : 3;
        drive(v.l1, 1'b1, v.we, v.addr, v.wdata);
        e.we  = v.we;
        e.err = v.err;
        if (v.we)       e.rdata = model_rd[m];
        else if (v.err) e.rdata = 32'h0;
        else            e.rdata = v.rdata;
        model_rd[m] = e.rdata;
        sb.push_back(e);
        gap = 0; stalls = 0; a = 1'b0;
        if (v.b2b) begin
            @(negedge clk);
            gap = 1;
        end
        while (gap < 20) begin
            #1;
            a = v.l1 ? ack1 : ack3;
            if (a) break;
            if (v.l1 ? stall1 : stall3) stalls++;
            @(negedge clk);
            gap++;
        end
        chk($sformatf("v%0d ack", k), 32'(a), 32'd1);
        chk($sformatf("v%0d ack_gap", k), 32'(gap), 32'(lat + int'(v.b2b)));
        chk($sformatf("v%0d stall_cycles", k), 32'(stalls), 32'(lat));
        e = sb.pop_front();
        chk($sformatf("v%0d rdata", k), v.l1 ? rdata1 : rdata3, e.rdata);
        chk($sformatf("v%0d err", k), 32'(v.l1 ? err1 : err3), 32'(e.err));
        if (!hold) begin
            drive(v.l1, 1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d ack_pulse", k), 32'(v.l1 ? ack1 : ack3), 32'd0);
            chk($sformatf("v%0d err_pulse", k), 32'(v.l1 ? err1 : err3), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    initial begin
        vec_t vx;
        for (int i = 0; i < 256; i++) begin
            dut3.u_array.r_mem[i] = pre(i);
            dut1.u_array.r_mem[i] = pre(i);
        end
        model_rd[0] = 32'h0;
        model_rd[1] = 32'h0;

        vecs[0]  = '{0, 0, 1, 32'h10,  32'hDEADBEEF, 32'h0,        0};
        vecs[1]  = '{0, 0, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0};
        vecs[2]  = '{0, 0, 1, 32'h20,  32'h1,        32'h0,        0};
        vecs[3]  = '{0, 1, 0, 32'h20,  32'h0,        32'h1,        0};
        vecs[4]  = '{0, 0, 0, 32'h400, 32'h0,        32'h0,        1};
        vecs[5]  = '{0, 0, 1, 32'h400, 32'h12345678, 32'h0,        1};
        vecs[6]  = '{0, 0, 0, 32'h0,   32'h0,        pre(0),       0};
        vecs[7]  = '{0, 0, 0, 32'h3FC, 32'h0,        pre(255),     0};
        vecs[8]  = '{1, 0, 1, 32'h8,   32'hCAFEF00D, 32'h0,        0};
        vecs[9]  = '{1, 0, 0, 32'h8,   32'h0,        32'hCAFEF00D, 0};
        vecs[10] = '{1, 0, 0, 32'h400, 32'h0,        32'h0,        1};
        vecs[11] = '{1, 1, 1, 32'h400, 32'h77777777, 32'h0,        1};
        vecs[12] = '{1, 1, 0, 32'h8,   32'h0,        32'hCAFEF00D, 0};

        repeat (3) @(negedge clk);
        #1;
        chk("rst ack3", 32'(ack3), 32'd0);
        chk("rst err3", 32'(err3), 32'd0);
        chk("rst rdata3", rdata3, 32'h0);
        chk("rst stall3", 32'(stall3), 32'd0);
        chk("rst ack1", 32'(ack1), 32'd0);
        chk("rst rdata1", rdata1, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], (i + 1 < 13) && vecs[i+1].b2b, i);
        end

        chk("mem3[4]", dut3.u_array.r_mem[4], 32'hDEADBEEF);
        chk("mem3[8]", dut3.u_array.r_mem[8], 32'h1);
        chk("mem3[0]", dut3.u_array.r_mem[0], pre(0));
        chk("mem1[2]", dut1.u_array.r_mem[2], 32'hCAFEF00D);
        chk("mem1[0]", dut1.u_array.r_mem[0], pre(0));

        // rdata holds across idle cycles
        vx = '{0, 0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0};
        run_vec(vx, 1'b0, 100);
        repeat (5) @(negedge clk);
        #1;
        chk("hold rdata", rdata3, 32'hDEADBEEF);
        @(negedge clk);

        // inputs changed during BUSY are ignored
        drive(0, 1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h30, 32'hBAD0BAD0);
        for (int i = 0; i < 10; i++) begin
            #1;
            if (ack3) break;
            @(negedge clk);
        end
        chk("busy ack", 32'(ack3), 32'd1);
        chk("busy rdata", rdata3, 32'h1);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("busy mem3[12]", dut3.u_array.r_mem[12], pre(12));
        model_rd[0] = 32'h1;
        @(negedge clk);

        // reset in the second cycle of a store
        drive(0, 1'b1, 1'b1, 32'h40, 32'h55);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid ack", 32'(ack3), 32'd0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("rst_mid stall", 32'(stall3), 32'd0);
        chk("rst_mid ack2", 32'(ack3), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst ack", 32'(ack3), 32'd0);
        chk("post_rst err", 32'(err3), 32'd0);
        chk("post_rst rdata", rdata3, 32'h0);
        chk("post_rst mem3[16]", dut3.u_array.r_mem[16], pre(16));
        model_rd[0] = 32'h0;
        model_rd[1] = 32'h0;
        @(negedge clk);
        vx = '{0, 0, 0, 32'h40, 32'h0, pre(16), 0};
        run_vec(vx, 1'b0, 101);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
